// File: rtl/layer_stream_sequencer.sv
// layer_stream_sequencer
// Captures the NN parallel neuron outputs of one fully-connected layer. It then
// replays them one word per clock, word 0 first, as the x_in/x_valid stream
// consumed by the next layer. Overrun and misaligned-valid events are latched
// into sticky flags that clear only on reset.
// Optional argmax unit: define LAYER_SEQ_ARGMAX_EN to build the running signed
// max that reports the winning neuron index at the end of every stream.
module layer_stream_sequencer #(
  parameter int NN        = 10,
  parameter int dataWidth = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NN-1:0]           i_valid,
  input  logic [NN*dataWidth-1:0] i_data,
  output logic                    o_x_valid,
  output logic [dataWidth-1:0]    o_x_data,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_overrun,
  output logic                    o_misalign,
  output logic [$clog2(NN)-1:0]   o_class,
  output logic                    o_class_valid
);

  localparam int IW = $clog2(NN);
  localparam logic [IW-1:0] LAST = IW'(NN - 1);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t                      state_q, state_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic signed [dataWidth-1:0] buf_q [NN];
  logic                        overrun_q, misalign_q;
  logic                        capture, misalign, load, done, ovr_set;
  logic                        send;
  logic signed [dataWidth-1:0] word_p0;

  // All valids high is a capture; a partial, nonzero valid vector is a misalign.
  assign capture  = &i_valid;
  assign misalign = (|i_valid) && !capture;
  assign send     = (state_q == S_SEND);
  assign word_p0  = buf_q[idx_q];

  // Next-state logic: stream from the buffer, and accept a new capture only
  // when idle or on the final word of the current stream.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    done    = 1'b0;
    ovr_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (capture) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) begin
          done = 1'b1;
          if (capture) begin
            load  = 1'b1;
            idx_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else if (capture) begin
          ovr_set = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, index and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      overrun_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      overrun_q  <= overrun_q | ovr_set;
      misalign_q <= misalign_q | misalign;
    end
  end

  // Word buffer, loaded in parallel on an accepted capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NN; k++) buf_q[k] <= '0;
    end else if (load) begin
      for (int k = 0; k < NN; k++) buf_q[k] <= i_data[k*dataWidth +: dataWidth];
    end
  end

  // Stream outputs come straight from registered state, so a reset clears them at once.
  assign o_x_valid  = send;
  assign o_busy     = send;
  assign o_x_data   = send ? word_p0 : '0;
  assign o_done     = done;
  assign o_overrun  = overrun_q;
  assign o_misalign = misalign_q;

`ifdef LAYER_SEQ_ARGMAX_EN
  logic signed [dataWidth-1:0] max_q, max_d;
  logic [IW-1:0]               arg_q, arg_d, class_q;
  logic                        class_vld_q;

  // Running max: word 0 seeds it, later words replace it only when strictly greater.
  always_comb begin
    max_d = max_q;
    arg_d = arg_q;
    if (send && ((idx_q == '0) || (word_p0 > max_q))) begin
      max_d = word_p0;
      arg_d = idx_q;
    end
  end

  // Latch the winner on the last word; the valid pulse lands one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q       <= '0;
      arg_q       <= '0;
      class_q     <= '0;
      class_vld_q <= 1'b0;
    end else begin
      max_q       <= max_d;
      arg_q       <= arg_d;
      class_vld_q <= done;
      if (done) class_q <= arg_d;
    end
  end

  assign o_class       = class_q;
  assign o_class_valid = class_vld_q;
`else
  assign o_class       = '0;
  assign o_class_valid = 1'b0;
`endif

endmodule

// File: doc/layer_stream_sequencer.md
# layer_stream_sequencer

Sequences parallel neuron results from one fully-connected layer into the serial `x_in`/`x_valid` stream consumed by the next layer. It captures the `NN` words a layer presents on `x_out` when every neuron's `o_valid` is high. It then replays them one word per clock, word 0 first, and flags protocol violations. An optional argmax unit reports the winning neuron index, for use after the final layer.

## Interface
- `NN`, 10, neuron count of the producing layer (≥2)
- `dataWidth`, 16, width of each neuron output word (signed fixed point)
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `i_valid`  in  NN  per-neuron output valid from the producing layer
- `i_data`  in  NN*dataWidth  packed neuron outputs; word k at `[k*dataWidth +: dataWidth]`
- `o_x_valid`  out  1  stream word valid, to the next layer's `x_valid`
- `o_x_data`  out  dataWidth  stream word, to the next layer's `x_in`
- `o_busy`  out  1  high while a stream is in progress
- `o_done`  out  1  one-cycle pulse coincident with the last stream word
- `o_overrun`  out  1  sticky; a capture was refused because the block was busy
- `o_misalign`  out  1  sticky; `i_valid` was nonzero but not all ones
- `o_class`  out  $clog2(NN)  argmax index (argmax build only)
- `o_class_valid`  out  1  one-cycle pulse when `o_class` updates (argmax build only)

Clock and reset: a single clock, `clk`. Reset `rst` is asynchronous and active-high.

## Operation
- Buffer: `NN` registers of `dataWidth` bits; index counter `idx` of width $clog2(NN).
- **Capture condition:** `i_valid == {NN{1'b1}}` at a rising edge.
- **IDLE:**
  - On the capture condition, load all `NN` words and set `idx = 0`.
  - Go to SEND.
- **SEND:**
  - Each cycle, drive `o_x_data = buf[idx]` with `o_x_valid = 1`, then increment `idx`.
  - At `idx == NN-1`, assert `o_done`.
  - In that same cycle, return to IDLE, unless the capture condition is also true there (see back-to-back below).
- **Back-to-back:** a capture in the SEND cycle with `idx == NN-1` is accepted.
  - The buffer reloads and `idx` resets to 0.
  - The block stays in SEND, so there is no gap between streams.
- **Overrun:** a capture in SEND with `idx < NN-1` is ignored.
  - Set `o_overrun`.
  - The stream in progress continues unaltered.
- **Misalign:** `i_valid != 0` and `i_valid != all ones` sets `o_misalign`.
  - No capture occurs.
  - State is unaffected.
- **Sticky flags:** `o_overrun` and `o_misalign` clear only on `rst`.
- **Bypass:** `o_x_data` is registered from the buffer; it is never combinationally bypassed from `i_data`.

## Timing
- **Reset values:** every output is 0, state is IDLE, `idx = 0`, and the buffer is 0.
- **Stream latency:** capture at edge T gives `o_x_valid = 1` from cycle T+1 through T+NN.
  - Word k appears in cycle T+1+k.
  - `o_done` is high only in cycle T+NN.
- **Busy window:** `o_busy` equals `o_x_valid`.
- **Argmax latency:** `o_class_valid` pulses in cycle T+NN+1. During a back-to-back stream it still pulses, overlapping the first word of the next stream.
- **Reset mid-stream:** the stream aborts immediately.
  - No `o_done` and no `o_class_valid`.
  - After reset is released, the next capture behaves normally.
- **Simultaneous misalign and overrun:** impossible, because the capture condition and the misalign condition are mutually exclusive.

## Configuration
- Macro: `LAYER_SEQ_ARGMAX_EN`.
- **Defined:**
  - A running signed max tracks the streamed words.
  - On ties, the lower index wins: update only on a strictly greater word.
  - `o_class` is registered at the end of each stream and holds until the next stream completes.
  - `o_class_valid` pulses one cycle as specified above.
- **Undefined:** `o_class` and `o_class_valid` are tied to 0, and no comparator logic is built.

## Test plan
- **Single stream (NN=10):** capture words 0x0010,0x0020,…,0x00A0 at edge T.
  - Stream presents 0x0010..0x00A0 in cycles T+1..T+10.
  - `o_done` only at T+10.
  - `o_busy` falls at T+11.
- **Back-to-back:** second capture (0x0100..0x0A00) at T+10.
  - 20 contiguous valid cycles with no gap.
  - `o_done` at T+10 and T+20.
- **Overrun:** second capture at T+4.
  - First stream is unchanged; only 10 words are output.
  - `o_overrun = 1` from T+5 until reset.
- **Misalign:** `i_valid = 10'b0000000111` for one cycle.
  - No stream starts.
  - `o_misalign = 1` sticky; a later full capture still streams correctly.
- **Argmax (macro defined):** words {-5, 3, 7, 7, -1, 0, 2, 1, 6, -8}.
  - `o_class = 2`, with `o_class_valid` pulse at T+11.
  - All-negative words {-3, -1, -2, …} give `o_class = 1`.
- **Reset mid-stream:** assert `rst` at T+5.
  - All outputs are 0 immediately.
  - No `o_done` follows.
  - A fresh capture after reset streams all 10 words.
